// File: rtl/ref_writer_if.sv
// rtl/ref_writer_if.sv - Command/data input stream and arbiter write-port bundle for ref_writer
interface ref_writer_if #(parameter int ID_WIDTH = 12);
  logic [27:0]         ref_addr_in;
  logic [27:0]         ref_length_in;
  logic                ref_info_valid_in;
  logic                ref_info_rdy_out;
  logic [127:0]        ref_data_in;
  logic                ref_data_valid_in;
  logic                ref_data_rdy_out;
  logic [ID_WIDTH-3:0] wr_id_out;
  logic [32:0]         wr_addr_out;
  logic [7:0]          wr_len_out;
  logic                wr_info_valid_out;
  logic                wr_info_rdy_in;
  logic [255:0]        wr_data_out;
  logic                wr_data_valid_out;
  logic                wr_data_last_out;
  logic                wr_data_rdy_in;
  logic                wr_resp_in;
  logic                done_out;

  modport master (
    input  ref_addr_in, ref_length_in, ref_info_valid_in, ref_data_in, ref_data_valid_in,
           wr_info_rdy_in, wr_data_rdy_in, wr_resp_in,
    output ref_info_rdy_out, ref_data_rdy_out, wr_id_out, wr_addr_out, wr_len_out,
           wr_info_valid_out, wr_data_out, wr_data_valid_out, wr_data_last_out, done_out
  );

  modport slave (
    output ref_addr_in, ref_length_in, ref_info_valid_in, ref_data_in, ref_data_valid_in,
           wr_info_rdy_in, wr_data_rdy_in, wr_resp_in,
    input  ref_info_rdy_out, ref_data_rdy_out, wr_id_out, wr_addr_out, wr_len_out,
           wr_info_valid_out, wr_data_out, wr_data_valid_out, wr_data_last_out, done_out
  );
endinterface

// File: rtl/ref_writer.sv
// rtl/ref_writer.sv - Packs 128-bit reference words into 256-bit beats and writes them
// to DRAM in bursts capped by MAX_BURST_LEN and the 4 KB boundary.
module ref_writer #(
  parameter int C0_C_S_AXI_ID_WIDTH = 12,
  parameter int MAX_BURST_LEN       = 16,
  parameter int WR_ID               = 0
) (
  input logic          clk,
  input logic          rst,
  ref_writer_if.master bus
);
  typedef enum logic [2:0] {IDLE, REQ, DATA, RESP, DONE} state_t;

  localparam logic [7:0] MAX_BEATS = 8'(MAX_BURST_LEN);

  state_t       state;
  logic [27:0]  addr;
  logic [27:0]  remaining;
  logic [7:0]   burst_beats;
  logic [7:0]   beats_packed;
  logic         half;
  logic [127:0] low_word;

  logic [7:0]   beats_calc;
  logic         beat_take;
  logic         word_take;

  // Blocks left before the next 4 KB page (128 blocks), then clamp by the other two limits.
  always_comb begin
    beats_calc = 8'd128 - {1'b0, addr[6:0]};
    if (MAX_BEATS < beats_calc) beats_calc = MAX_BEATS;
    if (remaining < {20'd0, beats_calc}) beats_calc = remaining[7:0];
  end

  assign beat_take = bus.wr_data_valid_out && bus.wr_data_rdy_in;
  assign bus.ref_data_rdy_out = (state == DATA) &&
                                (!bus.wr_data_valid_out || bus.wr_data_rdy_in) &&
                                (beats_packed < burst_beats);
  assign word_take = bus.ref_data_rdy_out && bus.ref_data_valid_in;
  assign bus.wr_id_out = (C0_C_S_AXI_ID_WIDTH-2)'(WR_ID);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                 <= IDLE;
      addr                  <= '0;
      remaining             <= '0;
      burst_beats           <= '0;
      beats_packed          <= '0;
      half                  <= 1'b0;
      low_word              <= '0;
      bus.ref_info_rdy_out  <= 1'b0;
      bus.wr_info_valid_out <= 1'b0;
      bus.wr_addr_out       <= '0;
      bus.wr_len_out        <= '0;
      bus.wr_data_out       <= '0;
      bus.wr_data_valid_out <= 1'b0;
      bus.wr_data_last_out  <= 1'b0;
      bus.done_out          <= 1'b0;
    end else begin
      bus.done_out <= 1'b0;
      case (state)
        IDLE: begin
          bus.ref_info_rdy_out <= 1'b1;
          if (bus.ref_info_rdy_out && bus.ref_info_valid_in) begin
            bus.ref_info_rdy_out <= 1'b0;
            addr                 <= bus.ref_addr_in;
            remaining            <= bus.ref_length_in;
            state                <= (bus.ref_length_in == 28'd0) ? DONE : REQ;
          end
        end
        REQ: begin
          if (!bus.wr_info_valid_out) begin
            bus.wr_info_valid_out <= 1'b1;
            bus.wr_addr_out       <= {addr, 5'b0};
            bus.wr_len_out        <= beats_calc - 8'd1;
            burst_beats           <= beats_calc;
          end else if (bus.wr_info_rdy_in) begin
            bus.wr_info_valid_out <= 1'b0;
            beats_packed          <= '0;
            half                  <= 1'b0;
            state                 <= DATA;
          end
        end
        DATA: begin
          // A completing word may refill the beat register in the same cycle it drains.
          if (word_take && half) begin
            bus.wr_data_out       <= {bus.ref_data_in, low_word};
            bus.wr_data_valid_out <= 1'b1;
            bus.wr_data_last_out  <= (beats_packed == burst_beats - 8'd1);
            beats_packed          <= beats_packed + 8'd1;
            half                  <= 1'b0;
          end else begin
            if (word_take) begin
              low_word <= bus.ref_data_in;
              half     <= 1'b1;
            end
            if (beat_take) begin
              bus.wr_data_valid_out <= 1'b0;
              bus.wr_data_last_out  <= 1'b0;
            end
          end
          if (beat_take && bus.wr_data_last_out) state <= RESP;
        end
        RESP: begin
          if (bus.wr_resp_in) begin
            addr      <= addr + {20'd0, burst_beats};
            remaining <= remaining - {20'd0, burst_beats};
            state     <= (remaining == {20'd0, burst_beats}) ? DONE : REQ;
          end
        end
        DONE: begin
          bus.done_out         <= 1'b1;
          bus.ref_info_rdy_out <= 1'b1;
          state                <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ref_writer.sv
// tb/tb_ref_writer.sv - Randomized self-checking bench for ref_writer against a burst-splitting model
module tb_ref_writer;
  localparam int MAXB = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ref_writer_if #(.ID_WIDTH(12)) bus ();

  ref_writer #(.C0_C_S_AXI_ID_WIDTH(12), .MAX_BURST_LEN(MAXB), .WR_ID(0)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  logic [127:0] words[$];
  logic [32:0]  exp_addr[$], obs_addr[$];
  logic [7:0]   exp_len[$],  obs_len[$];
  logic [255:0] exp_data[$], obs_data[$];
  logic         exp_last[$], obs_last[$];
  int hs_cycle, done_cycle, done_count, info_count, rdy_viol;

  task automatic idle_inputs();
    bus.ref_addr_in       = '0;
    bus.ref_length_in     = '0;
    bus.ref_info_valid_in = 1'b0;
    bus.ref_data_in       = '0;
    bus.ref_data_valid_in = 1'b0;
    bus.wr_info_rdy_in    = 1'b0;
    bus.wr_data_rdy_in    = 1'b0;
    bus.wr_resp_in        = 1'b0;
  endtask

  // Reference: split [a, a+l) into bursts by the three limits, beats are word pairs in order.
  task automatic build_model(input logic [27:0] a, input logic [27:0] l);
    int rem, b, k;
    logic [27:0] cur;
    words.delete(); exp_addr.delete(); exp_len.delete(); exp_data.delete(); exp_last.delete();
    for (int i = 0; i < 2 * int'(l); i++) words.push_back({$urandom, $urandom, $urandom, $urandom});
    rem = int'(l);
    cur = a;
    k = 0;
    while (rem > 0) begin
      b = 128 - int'(cur % 28'd128);
      if (b > MAXB) b = MAXB;
      if (b > rem) b = rem;
      exp_addr.push_back({cur, 5'b0});
      exp_len.push_back(8'(b - 1));
      for (int i = 0; i < b; i++) begin
        exp_data.push_back({words[2*k+1], words[2*k]});
        exp_last.push_back(i == b - 1);
        k++;
      end
      cur = cur + 28'(b);
      rem -= b;
    end
  endtask

  // mode 0: no backpressure; 1: beat ready toggles, random word gaps; 2: everything random.
  task automatic run_cmd(input logic [27:0] a, input logic [27:0] l, input int mode, input int abort_beats);
    int cyc, widx, resp_timer;
    bit info_hs, data_hs, beat_hs, beat_last, finished;
    obs_addr.delete(); obs_len.delete(); obs_data.delete(); obs_last.delete();
    hs_cycle = -1; done_cycle = -1; done_count = 0; info_count = 0; rdy_viol = 0;
    cyc = 0; widx = 0; resp_timer = -1; finished = 0;
    @(posedge clk); #1;
    bus.ref_addr_in       = a;
    bus.ref_length_in     = l;
    bus.ref_info_valid_in = 1'b1;
    bus.ref_data_valid_in = (words.size() > 0);
    bus.ref_data_in       = (words.size() > 0) ? words[0] : '0;
    bus.wr_info_rdy_in    = 1'b1;
    bus.wr_data_rdy_in    = 1'b1;
    bus.wr_resp_in        = 1'b0;
    while (!finished && cyc < 3000) begin
      @(negedge clk);
      info_hs   = bus.ref_info_valid_in && bus.ref_info_rdy_out;
      data_hs   = bus.ref_data_valid_in && bus.ref_data_rdy_out;
      beat_hs   = bus.wr_data_valid_out && bus.wr_data_rdy_in;
      beat_last = bus.wr_data_last_out;
      if (info_hs) hs_cycle = cyc;
      if (bus.wr_info_valid_out) info_count++;
      if (bus.wr_info_valid_out && bus.wr_info_rdy_in) begin
        obs_addr.push_back(bus.wr_addr_out);
        obs_len.push_back(bus.wr_len_out);
      end
      if (beat_hs) begin
        obs_data.push_back(bus.wr_data_out);
        obs_last.push_back(beat_last);
      end
      if (bus.ref_data_rdy_out && bus.wr_data_valid_out && !bus.wr_data_rdy_in) rdy_viol++;
      if (bus.done_out) begin
        done_count++;
        if (done_cycle < 0) done_cycle = cyc;
      end
      @(posedge clk); #1;
      cyc++;
      if (info_hs) bus.ref_info_valid_in = 1'b0;
      if (data_hs) widx++;
      if (!(bus.ref_data_valid_in && !data_hs)) begin
        bus.ref_data_valid_in = (widx < words.size()) && (mode == 0 || $urandom_range(0, 3) != 0);
        bus.ref_data_in       = (widx < words.size()) ? words[widx] : '0;
      end
      bus.wr_data_rdy_in = (mode == 0) ? 1'b1 : (mode == 1) ? ~bus.wr_data_rdy_in : 1'($urandom_range(0, 1));
      bus.wr_info_rdy_in = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.wr_resp_in = 1'b0;
      if (beat_hs && beat_last) resp_timer = (mode == 0) ? 0 : int'($urandom_range(0, 3));
      if (resp_timer == 0) bus.wr_resp_in = 1'b1;
      if (resp_timer >= 0) resp_timer--;
      if (abort_beats > 0 && obs_data.size() >= abort_beats) finished = 1;
      if (done_cycle >= 0 && cyc >= done_cycle + 3) finished = 1;
    end
    if (!(abort_beats > 0)) idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.wr_info_valid_out, bus.wr_data_valid_out, bus.wr_data_last_out,
         bus.ref_data_rdy_out, bus.ref_info_rdy_out, bus.done_out} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, need 000000", {bus.wr_info_valid_out, bus.wr_data_valid_out,
               bus.wr_data_last_out, bus.ref_data_rdy_out, bus.ref_info_rdy_out, bus.done_out});
    end
    checks++;
    if (bus.wr_id_out !== 10'd0) begin
      errors++;
      $display("FAIL reset_id: got %h, need 0", bus.wr_id_out);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.ref_info_rdy_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_info_rdy: got %b, need 1", bus.ref_info_rdy_out);
    end
  endtask

  task automatic test_transfer(input string name, input logic [27:0] a, input logic [27:0] l, input int mode);
    build_model(a, l);
    run_cmd(a, l, mode, 0);
    checks++;
    if (obs_addr.size() != exp_addr.size()) begin
      errors++;
      $display("FAIL %s_burst_count: got %0d, need %0d", name, obs_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      checks++;
      if (obs_addr[i] !== exp_addr[i] || obs_len[i] !== exp_len[i]) begin
        errors++;
        $display("FAIL %s_burst%0d: got addr=%h len=%0d, need addr=%h len=%0d",
                 name, i, obs_addr[i], obs_len[i], exp_addr[i], exp_len[i]);
      end
    end
    checks++;
    if (obs_data.size() != exp_data.size()) begin
      errors++;
      $display("FAIL %s_beat_count: got %0d, need %0d", name, obs_data.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      checks++;
      if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i]) begin
        errors++;
        $display("FAIL %s_beat%0d: got last=%b data=%h, need last=%b data=%h",
                 name, i, obs_last[i], obs_data[i], exp_last[i], exp_data[i]);
      end
    end
    checks++;
    if (done_count != 1) begin
      errors++;
      $display("FAIL %s_done: got %0d pulses, need 1", name, done_count);
    end
    checks++;
    if (rdy_viol != 0) begin
      errors++;
      $display("FAIL %s_data_rdy: got %0d cycles ready with full beat held, need 0", name, rdy_viol);
    end
  endtask

  task automatic test_zero_len();
    build_model(28'h0000123, 28'd0);
    run_cmd(28'h0000123, 28'd0, 0, 0);
    checks++;
    if (info_count != 0) begin
      errors++;
      $display("FAIL zero_len_req: got %0d cycles of wr_info_valid_out, need 0", info_count);
    end
    checks++;
    if (done_count != 1 || hs_cycle < 0 || done_cycle - hs_cycle != 2) begin
      errors++;
      $display("FAIL zero_len_done: got %0d pulses at offset %0d, need 1 at offset 2",
               done_count, done_cycle - hs_cycle);
    end
  endtask

  task automatic test_reset_mid_burst();
    build_model(28'h0000020, 28'd8);
    run_cmd(28'h0000020, 28'd8, 0, 2);
    checks++;
    if (obs_data.size() != 2 || obs_data[0] !== exp_data[0] || obs_data[1] !== exp_data[1]) begin
      errors++;
      $display("FAIL mid_reset_prefix: got %0d beats, need 2 matching beats", obs_data.size());
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.wr_info_valid_out, bus.wr_data_valid_out, bus.wr_data_last_out,
         bus.ref_data_rdy_out, bus.ref_info_rdy_out, bus.done_out} !== 6'b0 ||
        bus.wr_addr_out !== 33'd0 || bus.wr_len_out !== 8'd0 || bus.wr_data_out !== 256'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got ctrl=%b addr=%h len=%0d, need all zero",
               {bus.wr_info_valid_out, bus.wr_data_valid_out, bus.wr_data_last_out,
                bus.ref_data_rdy_out, bus.ref_info_rdy_out, bus.done_out}, bus.wr_addr_out, bus.wr_len_out);
    end
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    test_transfer("after_reset", 28'h0000040, 28'd6, 0);
  endtask

  initial begin
    test_reset();
    test_transfer("single", 28'h0000010, 28'd4, 0);
    test_transfer("multi", 28'h0000000, 28'd40, 0);
    test_transfer("split4k", 28'h000007C, 28'd10, 1);
    test_transfer("wrap", 28'hFFFFFF8, 28'd12, 1);
    for (int r = 0; r < 3; r++)
      test_transfer("random", 28'($urandom), 28'($urandom_range(1, 40)), 2);
    test_zero_len();
    test_transfer("back_to_back", 28'h00003F0, 28'd20, 2);
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
